// File: rtl/vote_result_reader.sv
// ============================================================================
// Module   : vote_result_reader
// Purpose  : Snapshots four candidate counts, streams them as (id, count)
//            records over valid/ready and reports the winner and a tie flag.
//            Optional macro VOTE_RESULT_TOTAL_EN adds a fifth total record.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vote_result_reader #(
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] cand1_vote_recvd,
  input  logic [COUNT_W-1:0] cand2_vote_recvd,
  input  logic [COUNT_W-1:0] cand3_vote_recvd,
  input  logic [COUNT_W-1:0] cand4_vote_recvd,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_cand_id,
  output logic [COUNT_W+1:0] out_count,
  output logic               result_valid,
  output logic [2:0]         winner_id,
  output logic [COUNT_W-1:0] winner_count,
  output logic               tie
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef VOTE_RESULT_TOTAL_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  state_t             state;
  logic [COUNT_W-1:0] snap [4];
  logic [2:0]         idx;
  logic [COUNT_W-1:0] max_r;
  logic [2:0]         max_id;
  logic               tie_r;

  logic               xfer;
  logic [2:0]         next_idx;
  logic [COUNT_W-1:0] cur;
  logic [COUNT_W-1:0] nmax;
  logic [2:0]         nid;
  logic               ntie;
  logic [COUNT_W-1:0] fmax;
  logic [2:0]         fid;
  logic               ftie;

  assign xfer     = out_valid && out_ready;
  assign next_idx = idx + 3'd1;
  assign cur      = snap[idx[1:0]];

  // Running maximum after folding in the record currently being transferred.
  always_comb begin
    nmax = max_r;
    nid  = max_id;
    ntie = tie_r;
    if (idx == 3'd0) begin
      nmax = cur;
      nid  = 3'd1;
      ntie = 1'b0;
    end else if (cur > max_r) begin
      nmax = cur;
      nid  = next_idx;
      ntie = 1'b0;
    end else if (cur == max_r) begin
      ntie = 1'b1;
    end
  end

`ifdef VOTE_RESULT_TOTAL_EN
  logic [COUNT_W+1:0] total;
  assign total = {2'b00, snap[0]} + {2'b00, snap[1]} +
                 {2'b00, snap[2]} + {2'b00, snap[3]};
  // The total record comes last, so the registered maximum is already final.
  assign fmax = max_r;
  assign fid  = max_id;
  assign ftie = tie_r;
`else
  assign fmax = nmax;
  assign fid  = nid;
  assign ftie = ntie;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      for (int i = 0; i < 4; i++) snap[i] <= '0;
      idx          <= '0;
      max_r        <= '0;
      max_id       <= '0;
      tie_r        <= 1'b0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_cand_id  <= '0;
      out_count    <= '0;
      result_valid <= 1'b0;
      winner_id    <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (start) begin
            snap[0]     <= cand1_vote_recvd;
            snap[1]     <= cand2_vote_recvd;
            snap[2]     <= cand3_vote_recvd;
            snap[3]     <= cand4_vote_recvd;
            idx         <= 3'd0;
            busy        <= 1'b1;
            out_valid   <= 1'b1;
            out_cand_id <= 3'd1;
            out_count   <= {2'b00, cand1_vote_recvd};
            state       <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (!idx[2]) begin
              max_r  <= nmax;
              max_id <= nid;
              tie_r  <= ntie;
            end
            if (idx == LAST_IDX) begin
              out_valid    <= 1'b0;
              result_valid <= 1'b1;
              if (fmax == '0) begin
                winner_id    <= 3'd0;
                winner_count <= '0;
                tie          <= 1'b0;
              end else begin
                winner_id    <= fid;
                winner_count <= fmax;
                tie          <= ftie;
              end
              state <= DONE;
            end else begin
              idx <= next_idx;
`ifdef VOTE_RESULT_TOTAL_EN
              if (idx == 3'd3) begin
                out_cand_id <= 3'd0;
                out_count   <= total;
              end else begin
                out_cand_id <= idx + 3'd2;
                out_count   <= {2'b00, snap[next_idx[1:0]]};
              end
`else
              out_cand_id <= idx + 3'd2;
              out_count   <= {2'b00, snap[next_idx[1:0]]};
`endif
            end
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
